// File: rtl/random_range_gen.sv
// Bounded pseudo-random source: free-running Galois LFSR with optional seeding
// from the seconds counter, plus a bit-serial modulo engine behind a req/valid/busy handshake.
module random_range_gen #(
    parameter int               WIDTH = 8,
    parameter int               SEC_W = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
    input  logic             clk_1hz,
    input  logic             rst,
    input  logic [SEC_W-1:0] sec,
    input  logic             seed_load,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] rand_o,
    output logic             valid,
    output logic             busy
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        REDUCE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] rand_q, rand_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] sec_w;
    logic [WIDTH-1:0] seeded;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_new;

    assign sec_w  = WIDTH'(sec);
    assign seeded = lfsr_q ^ sec_w;

    // Seeding replaces the step; an all-zero result would lock the LFSR, so it is forced to 1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = (seeded == '0) ? WIDTH'(1) : seeded;
        end else if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ TAPS;
        end else begin
            lfsr_d = lfsr_q >> 1;
        end
    end

    // Restoring division step: sample is shifted so its MSB is always the next bit to bring down.
    always_comb begin
        trial   = {rem_q, sample_q[WIDTH-1]};
        rem_new = trial[WIDTH-1:0];
        if (trial >= {1'b0, lim_q}) begin
            rem_new = WIDTH'(trial - {1'b0, lim_q});
        end
    end

    always_comb begin
        state_d  = state_q;
        rand_d   = rand_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        sample_d = sample_q;
        lim_d    = lim_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (limit == '0) begin
                        rand_d  = lfsr_q;
                        valid_d = 1'b1;
                    end else begin
                        sample_d = lfsr_q;
                        lim_d    = limit;
                        rem_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = REDUCE;
                    end
                end
            end
            REDUCE: begin
                rem_d    = rem_new;
                sample_d = sample_q << 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    rand_d  = rem_new;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1hz) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= WIDTH'(1);
            rand_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            sample_q <= '0;
            lim_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            rand_q   <= rand_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            sample_q <= sample_d;
            lim_q    <= lim_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rand_o = rand_q;
    assign valid  = valid_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_random_range_gen.sv
// Directed bench for random_range_gen (WIDTH=8, TAPS=B8): per-edge vector table
// for LFSR/seeding, hand sequences for modulo latency, handshake, reset and period.
module tb_random_range_gen;

    logic       clk_1hz = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sec = '0;
    logic       seed_load = 1'b0;
    logic       req = 1'b0;
    logic [7:0] limit = '0;
    logic [7:0] rand_o;
    logic       valid;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;

    random_range_gen #(.WIDTH(8), .SEC_W(8), .TAPS(8'hB8)) dut (
        .clk_1hz   (clk_1hz),
        .rst       (rst),
        .sec       (sec),
        .seed_load (seed_load),
        .req       (req),
        .limit     (limit),
        .rand_o    (rand_o),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk_1hz = ~clk_1hz;

    typedef struct {
        logic       rst;
        logic       seed;
        logic [7:0] sec;
        logic       req;
        logic [7:0] lim;
        logic [7:0] e_rand;
        logic       e_valid;
        logic       e_busy;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic drive(input logic r, input logic sl, input logic [7:0] s,
                         input logic q, input logic [7:0] l);
        rst = r; seed_load = sl; sec = s; req = q; limit = l;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Capture after pre_edges idle edges, then watch busy/valid for the full latency.
    task automatic do_mod(input string name, input int pre_edges, input logic [7:0] lim,
                          input logic [7:0] exp, input bit poke);
        int vpulses;
        do_reset();
        for (int i = 0; i < pre_edges; i++) tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1, lim);
        tick();
        $display("%s: capture limit=%0d busy=%0b valid=%0b", name, lim, busy, valid);
        chk({name, "_busy_cap"}, busy, 1);
        vpulses = 0;
        for (int k = 1; k <= 8; k++) begin
            if (poke && (k == 3 || k == 8)) drive(1'b0, 1'b0, 8'hFF, 1'b1, 8'h03);
            else drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            tick();
            if (k < 8) begin
                if (valid) vpulses++;
                if (!busy) chk({name, "_busy_mid"}, busy, 1);
            end
        end
        $display("%s: done rand=%0d valid=%0b busy=%0b", name, rand_o, valid, busy);
        chk({name, "_early_valid"}, vpulses, 0);
        chk({name, "_valid"}, valid, 1);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_rand"}, rand_o, exp);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        chk({name, "_valid_after"}, valid, 0);
        chk({name, "_rand_hold"}, rand_o, exp);
    endtask

    initial begin
        int first_ret;
        int zeros;
        int distinct;
        bit seen[256];

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'hB8, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h5C, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h2E, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h17, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'hB3, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hB3, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h0F, 1'b1, 8'h00, 8'hB8, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'hB7, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'hE3, 1'b1, 1'b0};

        #1;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].seed, tbl[i].sec, tbl[i].req, tbl[i].lim);
            tick();
            $display("vec %0d: rand=%0h valid=%0b busy=%0b", i, rand_o, valid, busy);
            chk($sformatf("vec%0d_rand", i), rand_o, tbl[i].e_rand);
            chk($sformatf("vec%0d_valid", i), valid, tbl[i].e_valid);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
        end

        do_mod("mod_5C_10", 2, 8'd10, 8'd2, 1'b0);
        do_mod("mod_B8_1", 1, 8'd1, 8'd0, 1'b0);
        do_mod("mod_B8_255", 1, 8'd255, 8'd184, 1'b0);
        do_mod("mod_B8_B8", 1, 8'hB8, 8'd0, 1'b0);
        do_mod("mod_poke", 2, 8'd10, 8'd2, 1'b1);

        // Reset at iteration 4 abandons the request.
        do_reset();
        tick(); tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'd10);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) tick();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        $display("rst_mid: rand=%0h valid=%0b busy=%0b", rand_o, valid, busy);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", valid, 0);
        chk("rst_mid_rand", rand_o, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        zeros = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (valid) zeros++;
        end
        chk("rst_mid_no_valid", zeros, 0);
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        tick();
        $display("rst_mid_lfsr: rand=%0h", rand_o);
        chk("rst_mid_lfsr", rand_o, 8'h01);

        // Period: after reset, sample the raw LFSR every edge.
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        tick();
        chk("period_start", rand_o, 8'h01);
        first_ret = -1;
        zeros = 0;
        distinct = 1;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[1] = 1'b1;
        for (int s = 1; s <= 260; s++) begin
            tick();
            if (rand_o == 8'h00) zeros++;
            if (first_ret < 0) begin
                if (rand_o == 8'h01) first_ret = s;
                else if (!seen[rand_o]) begin
                    seen[rand_o] = 1'b1;
                    distinct++;
                end
            end
        end
        $display("period: return=%0d zeros=%0d distinct=%0d", first_ret, zeros, distinct);
        chk("period_len", first_ret, 255);
        chk("period_zero", zeros, 0);
        chk("period_distinct", distinct, 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/random_range_gen.md
Name: random_range_gen

Overview:
- Parametrised pseudo-random number source for the game logic, clocked on the 1 Hz tick domain.
- Free-running Galois LFSR, optionally re-seeded from the live seconds counter.
- Each request produces one value bounded to [0, limit-1] through a fixed-latency shift-subtract modulo engine, with a req/valid/busy handshake.
- Replaces ad-hoc seconds-times-constant randomisers; feeds spawn/position logic.

Parameters:
- WIDTH, 8, LFSR and result width (supported 4..16).
- SEC_W, 8, width of the sec input.
- TAPS, 8'hB8, Galois feedback mask, WIDTH bits wide; must be a maximal-length mask for WIDTH.

Ports:
- clk_1hz  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sec  input  SEC_W  seconds counter value used as seed material.
- seed_load  input  1  XOR sec into the LFSR this cycle instead of stepping.
- req  input  1  request a new bounded value; sampled only when idle.
- limit  input  WIDTH  exclusive upper bound; 0 means unbounded (raw LFSR value).
- rand  output  WIDTH  last produced value; held until the next result.
- valid  output  1  one-cycle pulse; rand is new.
- busy  output  1  high while the modulo engine runs.

Behaviour:
- Reset (clk_1hz edge with rst=1): lfsr=1, rand=0, valid=0, busy=0, state=IDLE, iteration count=0. Reset overrides all other inputs. Reset mid-operation abandons the request; no valid is produced.
- LFSR: on every non-reset edge, exactly one of the following applies:
  - seed_load=1: lfsr <= lfsr ^ sec_w, where sec_w is sec zero-extended or truncated to its low WIDTH bits. If the result is 0, lfsr <= 1.
  - seed_load=0: lfsr <= lfsr[0] ? ((lfsr>>1) ^ TAPS) : (lfsr>>1).
- The LFSR never holds 0.
- FSM states: IDLE, REDUCE.
- IDLE:
  - req=0: valid <= 0.
  - req=1 and limit=0: rand <= current lfsr (pre-update value), valid <= 1, stay IDLE. Latency 1 edge.
  - req=1 and limit!=0: sample <= current lfsr (pre-update), lim <= limit, rem <= 0, cnt <= 0, busy <= 1, valid <= 0, go REDUCE.
- REDUCE: one iteration per edge, MSB first.
  - t = {rem, sample[WIDTH-1-cnt]}, computed WIDTH+1 bits wide.
  - rem <= (t >= lim) ? t - lim : t.
  - On iteration cnt = WIDTH-1: rand <= the new rem, valid <= 1, busy <= 0, go IDLE.
  - Total latency: WIDTH edges after the capture edge. Result = sample mod limit, always < limit.
- req while busy is ignored; it is not queued. req on the same edge REDUCE completes is also ignored. A new request is accepted only once IDLE is visible.
- limit and sec may change during REDUCE without effect on the operation in flight; lim is latched at capture.
- seed_load with req in the same IDLE cycle: the sample is the pre-seed lfsr value.
- valid is high for exactly one cycle per accepted request. rand is unchanged at all other times.

Test Plan:
- Sequence check (WIDTH=8, TAPS=8'hB8): release rst, idle edges, req with limit=0 on edge 1, then edges 2, 3, 4 → lfsr sequence 01, B8, 5C, 2E, 17, B3; rand=0x01 with valid on edge 1.
- Bounded result: req with limit=10 captured on edge 3 (sample 0x5C=92) → busy high 8 cycles, single valid pulse 8 edges after capture, rand=2.
- Modulo bounds: sample 0xB8 with limit=1 → rand=0. Sample 0xB8 with limit=255 → rand=184. Sample 0xB8 with limit=0xB8 → rand=0.
- Seeding: with lfsr=0x01, seed_load=1, sec=0x01 → lfsr=0x01 (zero guard), next edge → 0xB8. With lfsr=0xB8, sec=0x0F → lfsr=0xB7.
- Handshake: pulse req during REDUCE → no extra valid, result unchanged. Assert rst at iteration 4 → valid never pulses, busy=0, rand=0, lfsr=1 on the next edge.
- Period: free-run from reset, seed_load=0 → lfsr returns to 0x01 after exactly 255 steps and never reads 0.
